bloom_prefilter: RTL and testbench

- Passive snooper on the packet input stream (in_data/in_ctrl/in_wr/in_rdy), upstream of the datapath.
- Hashes each payload word into a programmable Bloom bit array and asserts a sticky bloom_match for the packet.
- The datapath samples bloom_match at end_of_pkt to decide whether the packet goes to CPU-mode inspection.
- Software programs array bits and can issue a clear sweep.

---
 rtl/bloom_if.sv | 28 ++
 rtl/bloom_prefilter.sv | 159 +++++++++++++++
 tb/tb_bloom_prefilter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bloom_if.sv
// bloom_if: snooped packet stream, array programming port and status of bloom_prefilter.
// With BLOOM_STATS_EN defined it also carries the pkt_cnt/hit_cnt counters.
interface bloom_if #(parameter int ADDR_W = 10);
   logic [63:0] in_data;
   logic [7:0] in_ctrl;
   logic in_wr;
   logic in_rdy;
   logic prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic clr_req;
   logic clr_busy;
   logic bloom_match;
   logic match_valid;
   logic [2:0] fsm_state;
`ifdef BLOOM_STATS_EN
   logic [15:0] pkt_cnt;
   logic [15:0] hit_cnt;
   modport master(output in_data, in_ctrl, in_wr, in_rdy, prog_we, prog_addr, clr_req,
                  input clr_busy, bloom_match, match_valid, fsm_state, pkt_cnt, hit_cnt);
   modport slave(input in_data, in_ctrl, in_wr, in_rdy, prog_we, prog_addr, clr_req,
                 output clr_busy, bloom_match, match_valid, fsm_state, pkt_cnt, hit_cnt);
`else
   modport master(output in_data, in_ctrl, in_wr, in_rdy, prog_we, prog_addr, clr_req,
                  input clr_busy, bloom_match, match_valid, fsm_state);
   modport slave(input in_data, in_ctrl, in_wr, in_rdy, prog_we, prog_addr, clr_req,
                 output clr_busy, bloom_match, match_valid, fsm_state);
`endif
endinterface

// File: rtl/bloom_prefilter.sv
// bloom_prefilter: passive snooper hashing payload words into a programmable Bloom array.
// Define BLOOM_STATS_EN to add saturating pkt_cnt/hit_cnt counters.
module bloom_prefilter #(
   parameter int ADDR_W = 10,
   parameter int SKIP_WORDS = 5,
   parameter int CLR_W = 32
) (
   input logic clk,
   input logic rst_bloom,
   bloom_if.slave bus
);
   localparam int N = 2 ** ADDR_W;
   localparam int NCLR = N / CLR_W;
   localparam int CW = NCLR > 1 ? $clog2(NCLR) : 1;
   localparam int NS = (64 + ADDR_W - 1) / ADDR_W;
   localparam int SW = $clog2(SKIP_WORDS + 2);
   typedef enum logic [2:0] {
      IDLE = 3'd0, HDR = 3'd1, SKIP = 3'd2, PAYLOAD = 3'd3, DONE = 3'd4, CLEAR = 3'd5
   } state_t;
   state_t state;
   logic [N-1:0] arr;
   logic [CW-1:0] clr_cnt;
   logic [SW-1:0] skip_cnt;
   logic cur_tag, orphan, bloom_match, match_valid;
   logic s1_vld, s1_last, s1_tag, s2_vld, s2_last, s2_tag, s3_vld, s3_last, s3_tag, s3_hit;
   logic [63:0] s1_word, word;
   logic [ADDR_W-1:0] h0, h1, h2;
   logic acc, is_hdr, is_pay, is_last, push_h, push_l, byte_seen;
   function automatic logic [ADDR_W-1:0] fold(input logic [63:0] x);
      logic [NS*ADDR_W-1:0] p;
      logic [ADDR_W-1:0] r;
      p = (NS*ADDR_W)'(x);
      r = '0;
      for (int i = 0; i < NS; i++) r ^= p[i*ADDR_W +: ADDR_W];
      return r;
   endfunction
   function automatic logic [63:0] bswap(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[i*8 +: 8] = x[(7-i)*8 +: 8];
      return r;
   endfunction
   always_comb begin
      acc = bus.in_wr && bus.in_rdy;
      is_hdr = bus.in_ctrl == 8'hFF;
      is_pay = bus.in_ctrl == 8'h00;
      is_last = !is_hdr && !is_pay;
      push_h = acc && ((state == PAYLOAD && !is_hdr) || (state == HDR && is_pay && SKIP_WORDS == 0));
      push_l = acc && is_last && (state == HDR || state == SKIP || state == PAYLOAD ||
                                  (orphan && (state == IDLE || state == CLEAR)));
      word = bus.in_data;
      byte_seen = 1'b0;
      for (int j = 0; j < 8; j++) begin
         byte_seen |= bus.in_ctrl[j];
         word[j*8 +: 8] = ($onehot(bus.in_ctrl) && !byte_seen) ? 8'h00 : bus.in_data[j*8 +: 8];
      end
   end
   always_ff @(posedge clk or posedge rst_bloom)
      if (rst_bloom) begin
         state <= IDLE;
         skip_cnt <= '0;
         clr_cnt <= '0;
         cur_tag <= 1'b0;
         orphan <= 1'b0;
         bloom_match <= 1'b0;
         match_valid <= 1'b0;
         s1_vld <= 1'b0;
         s1_last <= 1'b0;
         s1_tag <= 1'b0;
         s1_word <= '0;
         s2_vld <= 1'b0;
         s2_last <= 1'b0;
         s2_tag <= 1'b0;
         h0 <= '0;
         h1 <= '0;
         h2 <= '0;
         s3_vld <= 1'b0;
         s3_last <= 1'b0;
         s3_tag <= 1'b0;
         s3_hit <= 1'b0;
      end else begin
         s1_vld <= push_h;
         s1_last <= push_l;
         s1_tag <= cur_tag;
         s1_word <= word;
         s2_vld <= s1_vld;
         s2_last <= s1_last;
         s2_tag <= s1_tag;
         h0 <= fold(s1_word);
         h1 <= fold({s1_word[50:0], s1_word[63:51]} ^ 64'h9E3779B97F4A7C15);
         h2 <= fold(bswap(s1_word));
         s3_vld <= s2_vld;
         s3_last <= s2_last;
         s3_tag <= s2_tag;
         s3_hit <= arr[h0] & arr[h1] & arr[h2];
         // stale stages from a superseded packet carry the old tag and are dropped
         if (s3_tag == cur_tag) begin
            if (s3_vld && s3_hit) bloom_match <= 1'b1;
            if (s3_last) match_valid <= 1'b1;
         end
         if (push_l) orphan <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.clr_req) begin
                  state <= CLEAR;
                  clr_cnt <= '0;
               end else if (acc && is_hdr) state <= HDR;
            end
            HDR: begin
               if (acc && is_pay) begin
                  skip_cnt <= SW'(1);
                  state <= (SKIP_WORDS <= 1) ? PAYLOAD : SKIP;
               end else if (acc && is_last) state <= DONE;
            end
            SKIP: begin
               if (acc && is_pay) begin
                  skip_cnt <= skip_cnt + 1'b1;
                  if (skip_cnt + 1'b1 == SW'(SKIP_WORDS)) state <= PAYLOAD;
               end else if (acc && is_last) state <= DONE;
            end
            PAYLOAD: if (acc && is_last) state <= DONE;
            CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == CW'(NCLR - 1)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // a start seen during (or racing into) a sweep still frames a packet, just unhashed
         if (acc && is_hdr && (state == IDLE || state == DONE || state == CLEAR)) begin
            bloom_match <= 1'b0;
            match_valid <= 1'b0;
            cur_tag <= !cur_tag;
            skip_cnt <= '0;
            orphan <= state == CLEAR || bus.clr_req;
         end
      end
   always_ff @(posedge clk)
      if (state == CLEAR) arr[int'(clr_cnt)*CLR_W +: CLR_W] <= '0;
      else if (bus.prog_we) arr[bus.prog_addr] <= 1'b1;
   assign bus.bloom_match = bloom_match;
   assign bus.match_valid = match_valid;
   assign bus.clr_busy = state == CLEAR;
   assign bus.fsm_state = state;
`ifdef BLOOM_STATS_EN
   logic mv_d;
   logic [15:0] pkt_cnt, hit_cnt;
   always_ff @(posedge clk or posedge rst_bloom)
      if (rst_bloom) begin
         mv_d <= 1'b0;
         pkt_cnt <= '0;
         hit_cnt <= '0;
      end else begin
         mv_d <= match_valid;
         if (match_valid && !mv_d && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 1'b1;
         if (match_valid && !mv_d && bloom_match && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 1'b1;
      end
   assign bus.pkt_cnt = pkt_cnt;
   assign bus.hit_cnt = hit_cnt;
`endif
endmodule

// File: tb/tb_bloom_prefilter.sv
// tb_bloom_prefilter: directed checks of bloom_prefilter match framing, masking, clear and reset.
// Counter checks are included when BLOOM_STATS_EN is defined.
module tb_bloom_prefilter;
   logic clk = 1'b0;
   logic rst_bloom = 1'b1;
   always #5 clk = ~clk;
   bloom_if #(.ADDR_W(10)) bus();
   bloom_prefilter #(.ADDR_W(10), .SKIP_WORDS(5), .CLR_W(32)) dut (
      .clk(clk), .rst_bloom(rst_bloom), .bus(bus)
   );
   localparam logic [63:0] W1 = 64'h41545441434B2121;
   localparam logic [63:0] WD = 64'hDEADBEEF00000000;
   localparam logic [63:0] WG = 64'hDEADBEEF13579BDF;
   localparam logic [63:0] WN = 64'h0123456789ABCDEF;
   int n_cmp = 0;
   int n_bad = 0;
   logic [1023:0] marr = '0;
   logic e;
   function automatic logic [9:0] tfold(input logic [63:0] x);
      logic [9:0] r = '0;
      for (int i = 0; i < 64; i++) r[i % 10] ^= x[i];
      return r;
   endfunction
   function automatic logic [29:0] thash(input logic [63:0] w);
      logic [63:0] b;
      for (int i = 0; i < 8; i++) b[8*i +: 8] = w[56-8*i +: 8];
      return {tfold(w), tfold(((w << 13) | (w >> 51)) ^ 64'h9E3779B97F4A7C15), tfold(b)};
   endfunction
   function automatic logic look(input logic [63:0] w);
      logic [29:0] h = thash(w);
      return marr[h[29:20]] & marr[h[19:10]] & marr[h[9:0]];
   endfunction
   function automatic logic [63:0] tmask(input logic [63:0] w, input logic [7:0] c);
      for (int k = 0; k < 8; k++) if (c == 8'(1 << k)) return w & ({64{1'b1}} << (8*k));
      return w;
   endfunction
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic beat(input logic [7:0] c, input logic [63:0] d);
      bus.in_wr = 1'b1;
      bus.in_ctrl = c;
      bus.in_data = d;
      @(negedge clk);
      bus.in_wr = 1'b0;
      bus.in_ctrl = 8'h00;
      bus.in_data = '0;
   endtask
   task automatic prog(input logic [63:0] w);
      logic [29:0] h = thash(w);
      for (int i = 0; i < 3; i++) begin
         bus.prog_we = 1'b1;
         bus.prog_addr = h[10*i +: 10];
         marr[h[10*i +: 10]] = 1'b1;
         @(negedge clk);
      end
      bus.prog_we = 1'b0;
   endtask
   task automatic wait_sweep(input string tag, output int n);
      n = 0;
      while (bus.clr_busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      marr = '0;
      chk(tag, 16'(bus.clr_busy), 16'd0);
   endtask
   task automatic sweep(input string tag);
      int n;
      bus.clr_req = 1'b1;
      @(negedge clk);
      bus.clr_req = 1'b0;
      chk({tag, " state"}, 16'(bus.fsm_state), 16'd5);
      wait_sweep({tag, " end"}, n);
      chk({tag, " cycles"}, 16'(n), 16'd32);
   endtask
   task automatic pkt(input string tag, input logic [63:0] pw, input logic [63:0] lw,
                      input logic [7:0] lc, input logic c0, output logic exp);
      beat(8'hFF, 64'h00000000FFFFFFFF);
      if (c0) chk({tag, " bm@hdr"}, 16'(bus.bloom_match), 16'd0);
      for (int i = 0; i < 5; i++) begin
         beat(8'h00, 64'(i + 1));
         if (c0) chk({tag, " bm@skip"}, 16'(bus.bloom_match), 16'd0);
      end
      beat(8'h00, pw);
      beat(lc, lw);
      exp = look(pw) | look(tmask(lw, lc));
   endtask
   task automatic result(input string tag, input logic exp_bm);
      @(negedge clk);
      @(negedge clk);
      chk({tag, " mv@+2"}, 16'(bus.match_valid), 16'd0);
      @(negedge clk);
      chk({tag, " mv@+3"}, 16'(bus.match_valid), 16'd1);
      chk({tag, " bm"}, 16'(bus.bloom_match), 16'(exp_bm));
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      bus.in_wr = 1'b0;
      bus.in_rdy = 1'b1;
      bus.in_ctrl = 8'h00;
      bus.in_data = '0;
      bus.prog_we = 1'b0;
      bus.prog_addr = '0;
      bus.clr_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst bm", 16'(bus.bloom_match), 16'd0);
      chk("rst mv", 16'(bus.match_valid), 16'd0);
      chk("rst busy", 16'(bus.clr_busy), 16'd0);
      chk("rst state", 16'(bus.fsm_state), 16'd0);
      rst_bloom = 1'b0;
      @(negedge clk);
      sweep("sweep0");
      prog(W1);
      beat(8'hFF, 64'h0);
      chk("t1 hdr", 16'(bus.fsm_state), 16'd1);
      beat(8'h00, 64'd1);
      chk("t1 skip", 16'(bus.fsm_state), 16'd2);
      for (int i = 2; i <= 5; i++) beat(8'h00, 64'(i));
      chk("t1 payload", 16'(bus.fsm_state), 16'd3);
      beat(8'h00, W1);
      beat(8'h01, W1);
      chk("t1 done", 16'(bus.fsm_state), 16'd4);
      result("t1", 1'b1);
      bus.clr_req = 1'b1;
      @(negedge clk);
      bus.clr_req = 1'b0;
      pkt("t2 during clr", W1, W1, 8'h01, 1'b0, e);
      result("t2 during clr", 1'b0);
      wait_sweep("t2 sweep end", n);
      pkt("t2 cleared", W1, W1, 8'h01, 1'b0, e);
      result("t2 cleared", 1'b0);
      prog(WD);
      pkt("t3 mask10", WN, WG, 8'h10, 1'b0, e);
      result("t3 mask10", 1'b1);
      pkt("t3 nonhot", WN, WD, 8'h03, 1'b0, e);
      result("t3 nonhot", 1'b1);
      pkt("t3 full01", WN, WG, 8'h01, 1'b0, e);
      result("t3 full01", e);
      pkt("t3 mask80", WN, WG, 8'h80, 1'b0, e);
      result("t3 mask80", e);
      prog(W1);
      pkt("t4 a", W1, W1, 8'h01, 1'b0, e);
      pkt("t4 b", WN, WN, 8'h01, 1'b1, e);
      result("t4 b", 1'b0);
      beat(8'hFF, 64'h0);
      beat(8'h01, W1);
      chk("t5 runt state", 16'(bus.fsm_state), 16'd4);
      result("t5 runt", 1'b0);
      beat(8'hFF, 64'h0);
      for (int i = 1; i <= 5; i++) beat(8'h00, 64'(i));
      bus.in_rdy = 1'b0;
      beat(8'h00, W1);
      bus.in_rdy = 1'b1;
      beat(8'h01, WN);
      result("t6 rdy0", look(WN));
      beat(8'hFF, 64'h0);
      for (int i = 1; i <= 5; i++) beat(8'h00, 64'(i));
      beat(8'h00, W1);
      repeat (3) @(negedge clk);
      chk("t7 pre bm", 16'(bus.bloom_match), 16'd1);
      chk("t7 pre state", 16'(bus.fsm_state), 16'd3);
      rst_bloom = 1'b1;
      #1;
      chk("t7 rst bm", 16'(bus.bloom_match), 16'd0);
      chk("t7 rst state", 16'(bus.fsm_state), 16'd0);
      chk("t7 rst mv", 16'(bus.match_valid), 16'd0);
      @(negedge clk);
      rst_bloom = 1'b0;
      @(negedge clk);
      pkt("t7 kept", W1, W1, 8'h01, 1'b0, e);
      result("t7 kept", 1'b1);
`ifdef BLOOM_STATS_EN
      rst_bloom = 1'b1;
      @(negedge clk);
      rst_bloom = 1'b0;
      @(negedge clk);
      chk("st rst pkt", bus.pkt_cnt, 16'd0);
      chk("st rst hit", bus.hit_cnt, 16'd0);
      pkt("st p1", W1, W1, 8'h01, 1'b0, e);
      result("st p1", 1'b1);
      pkt("st p2", WN, WN, 8'h01, 1'b0, e);
      result("st p2", 1'b0);
      pkt("st p3", WN, W1, 8'h01, 1'b0, e);
      result("st p3", 1'b1);
      @(negedge clk);
      chk("st pkt", bus.pkt_cnt, 16'd3);
      chk("st hit", bus.hit_cnt, 16'd2);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
